// File: rtl/conv_1x1_acc_pingpong.sv
//------------------------------------------------------------------------------
// conv_1x1_acc_pingpong : channel-in accumulator with ping-pong result banks
// Optional macro CONV_1X1_ACC_RELU_EN fuses a ReLU ahead of the bank write.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_1x1_acc_pingpong #(
  parameter int DATA_WIDTH      = 16,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 48,
  parameter int IMAGE_SIZE      = 4096,
  parameter int BANK_DEPTH      = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out
);

  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(CHANNEL_NUM_IN);
  localparam int CNT_W     = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int AW        = $clog2(BANK_DEPTH);
  localparam int RAW       = $clog2(BANK_DEPTH + 1);
  localparam int TOTAL     = IMAGE_SIZE * CHANNEL_NUM_OUT;
  localparam int FW        = $clog2(TOTAL);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHANNEL_NUM_IN - 1);
  localparam logic [AW-1:0]    WR_LAST  = AW'(BANK_DEPTH - 1);
  localparam logic [RAW-1:0]   RD_END   = RAW'(BANK_DEPTH);
  localparam logic [FW-1:0]    F_LAST   = FW'(TOTAL - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                        r_state;
  logic                          r_run;
  logic [CNT_W-1:0]              r_cnt_in;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [AW-1:0]                 r_wr_addr;
  logic                          r_wr_sel;
  logic                          r_rd_sel;
  logic [1:0]                    r_bank_full;
  logic [RAW-1:0]                r_rd_addr;
  logic [FW-1:0]                 r_frame_cnt;
  logic [DATA_WIDTH-1:0]         r_bank [2][BANK_DEPTH];

  logic                          w_accept;
  logic                          w_wr_en;
  logic                          w_hs;
  logic signed [ACC_WIDTH-1:0]   w_ext;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic [DATA_WIDTH-1:0]         w_res;
  logic [FW-1:0]                 w_frame_nxt;

  // r_run keeps ready_out low through reset and until the first clock after it
  assign ready_out   = r_run & ~r_bank_full[r_wr_sel];
  assign w_accept    = valid_in & ready_out;
  assign w_wr_en     = w_accept & (r_cnt_in == CNT_LAST);
  assign w_hs        = valid_out & ready_in;
  assign w_ext       = ACC_WIDTH'($signed(pxl_in));
  assign w_sum       = (r_cnt_in == '0) ? w_ext : (r_acc + w_ext);
  assign w_frame_nxt = (r_frame_cnt == F_LAST) ? '0 : (r_frame_cnt + 1'b1);

  always_comb begin
    w_res = w_sum[DATA_WIDTH-1:0];
    if (w_sum > SAT_MAX) begin
      w_res = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_res = SAT_MIN[DATA_WIDTH-1:0];
    end
`ifdef CONV_1X1_ACC_RELU_EN
    if (w_sum[ACC_WIDTH-1]) begin
      w_res = '0;
    end
`endif
  end

  // Bank storage carries no reset: contents are only read once a full flag is set
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_bank[r_wr_sel][r_wr_addr] <= w_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_run       <= 1'b0;
      r_cnt_in    <= '0;
      r_acc       <= '0;
      r_wr_addr   <= '0;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_bank_full <= 2'b00;
      r_rd_addr   <= '0;
      r_frame_cnt <= '0;
      pxl_out     <= '0;
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
    end else begin
      r_run <= 1'b1;

      if (w_accept) begin
        r_cnt_in <= (r_cnt_in == CNT_LAST) ? '0 : (r_cnt_in + 1'b1);
        r_acc    <= w_sum;
        if (w_wr_en) begin
          if (r_wr_addr == WR_LAST) begin
            r_wr_addr             <= '0;
            r_bank_full[r_wr_sel] <= 1'b1;
            r_wr_sel              <= ~r_wr_sel;
          end else begin
            r_wr_addr <= r_wr_addr + 1'b1;
          end
        end
      end

      if (w_hs) begin
        r_frame_cnt <= w_frame_nxt;
      end

      // A fill on the write bank and a clear on the read bank touch different flag bits
      case (r_state)
        IDLE: begin
          if (r_bank_full[r_rd_sel]) begin
            pxl_out   <= r_bank[r_rd_sel][0];
            valid_out <= 1'b1;
            last_out  <= (r_frame_cnt == F_LAST);
            r_rd_addr <= RAW'(1);
            r_state   <= STREAM;
          end
        end
        STREAM: begin
          if (w_hs) begin
            if (r_rd_addr == RD_END) begin
              r_bank_full[r_rd_sel] <= 1'b0;
              r_rd_sel              <= ~r_rd_sel;
              valid_out             <= 1'b0;
              last_out              <= 1'b0;
              r_state               <= IDLE;
            end else begin
              pxl_out   <= r_bank[r_rd_sel][r_rd_addr[AW-1:0]];
              last_out  <= (w_frame_nxt == F_LAST);
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
